ad9238_sample_packer: RTL

Capture-side datapath stage feeding the ad9238_sample DMA path. It takes raw AD9238 12-bit offset-binary samples from one selected channel and converts them to signed 16-bit values. It packs two samples per 32-bit word and emits a frame of `frame_len` words on an AXI4-Stream master with `tlast` on the final word. Frame arm, channel select and length are driven from the ad9238_sample control registers; the stream output goes to the S2MM side of the SG DMA.

---
 rtl/ad9238_sample_packer_if.sv | 11 +
 rtl/ad9238_sample_packer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ad9238_sample_packer_if.sv
// AXI4-Stream word channel between the AD9238 sample packer and the S2MM DMA.
// Carries one 32-bit word holding two signed samples, plus the frame-end marker.
interface ad9238_sample_packer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ad9238_sample_packer.sv
// Converts AD9238 offset-binary samples from one channel to signed 16-bit,
// packs two per word and streams frames of frame_len words through a small FIFO.
module ad9238_sample_packer #(
    parameter int ADC_WIDTH  = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         start,
    input  logic                         ch_sel,
    input  logic [LEN_WIDTH-1:0]         frame_len,
    input  logic [ADC_WIDTH-1:0]         adc_data_a,
    input  logic [ADC_WIDTH-1:0]         adc_data_b,
    ad9238_sample_packer_if.master       m_axis,
    output logic                         busy,
    output logic                         overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]          PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // Offset binary to two's complement: flip the MSB, then sign-extend.
    function automatic logic [15:0] to_signed16(input logic [ADC_WIDTH-1:0] s);
        logic [ADC_WIDTH-1:0] t;
        t = {~s[ADC_WIDTH-1], s[ADC_WIDTH-2:0]};
        return {{(16-ADC_WIDTH){t[ADC_WIDTH-1]}}, t};
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   busy_r;
    logic [ADC_WIDTH-1:0]   adc_a_r;
    logic [ADC_WIDTH-1:0]   adc_b_r;
    logic                   ch_r;
    logic [LEN_WIDTH-1:0]   len_r;
    logic [LEN_WIDTH-1:0]   wcnt_r;
    logic                   phase_r;
    logic                   skip_r;
    logic [15:0]            lo_r;
    logic                   overflow_r;
    logic [32:0]            mem_r [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_r;
    logic [AW:0]            rd_ptr_r;

    logic [ADC_WIDTH-1:0]   sel_s;
    logic [15:0]            conv_s;
    logic                   load_s;
    logic                   cap_en_s;
    logic                   word_done_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   push_s;
    logic                   drop_s;
    logic                   pop_s;
    logic                   last_word_s;
    logic [32:0]            head_s;

    assign sel_s       = ch_r ? adc_b_r : adc_a_r;
    assign conv_s      = to_signed16(sel_s);
    assign load_s      = (state_r == ST_IDLE) && start && (frame_len != {LEN_WIDTH{1'b0}});
    // The first CAPTURE cycle still sees a sample taken before the start pulse.
    assign cap_en_s    = (state_r == ST_CAPTURE) && !skip_r;
    assign word_done_s = cap_en_s && phase_r;
    assign empty_s     = (wr_ptr_r == rd_ptr_r);
    assign full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_s      = word_done_s && !full_s;
    assign drop_s      = word_done_s && full_s;
    assign pop_s       = !empty_s && m_axis.tready;
    assign last_word_s = (wcnt_r == (len_r - LEN_ONE));
    assign head_s      = mem_r[rd_ptr_r[AW-1:0]];

    assign m_axis.tvalid = !empty_s;
    assign m_axis.tdata  = empty_s ? 32'd0 : head_s[31:0];
    assign m_axis.tlast  = empty_s ? 1'b0 : head_s[32];
    assign busy          = busy_r;
    assign overflow      = overflow_r;

    // Free-running input register for both ADC channels.
    always_ff @(posedge aclk) begin
        if (areset) begin
            adc_a_r <= {ADC_WIDTH{1'b0}};
            adc_b_r <= {ADC_WIDTH{1'b0}};
        end else begin
            adc_a_r <= adc_data_a;
            adc_b_r <= adc_data_b;
        end
    end

    // State register; busy is registered from the next state.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (push_s && last_word_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if (pop_s && head_s[32]) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Frame configuration, packing phase, word counter and sticky overflow.
    always_ff @(posedge aclk) begin
        if (areset) begin
            ch_r       <= 1'b0;
            len_r      <= {LEN_WIDTH{1'b0}};
            wcnt_r     <= {LEN_WIDTH{1'b0}};
            phase_r    <= 1'b0;
            skip_r     <= 1'b0;
            lo_r       <= 16'd0;
            overflow_r <= 1'b0;
        end else if (load_s) begin
            ch_r       <= ch_sel;
            len_r      <= frame_len;
            wcnt_r     <= {LEN_WIDTH{1'b0}};
            phase_r    <= 1'b0;
            skip_r     <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            skip_r <= 1'b0;
            if (cap_en_s) begin
                phase_r <= ~phase_r;
                if (!phase_r) begin
                    lo_r <= conv_s;
                end
                if (push_s) begin
                    wcnt_r <= wcnt_r + LEN_ONE;
                end
                // A dropped word does not count, so the frame still delivers frame_len words.
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    // FIFO storage: {last, odd sample, even sample}.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {last_word_s, conv_s, lo_r};
        end
    end

    // FIFO pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule
